// File: rtl/vram_cpu_vid.sv
// VDP VRAM block: one dual-port byte array shared by a TMS9918-style CPU
// port (two-byte address/register latch, auto-increment, read-ahead buffer,
// status read path) and an independent read-only video fetch port.
module vram_cpu_vid #(
  parameter int ADDR_WIDTH = 14,
  parameter int REG_BITS   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic                  rd_tick,
  input  logic                  wr_tick,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  input  logic [7:0]            status_in,
  output logic                  status_rd_tick,
  output logic                  reg_wr_tick,
  output logic [REG_BITS-1:0]   reg_num,
  output logic [7:0]            reg_data,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  input  logic                  vid_rd,
  output logic [7:0]            vid_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  typedef enum logic {FIRST, SECOND} state_t;

  state_t                state;
  logic [7:0]            latch;
  logic [ADDR_WIDTH-1:0] addr;

  // Prefetch request raised by a read setup or a data read; the array read
  // happens on the following edge.
  logic                  pf_vld_p1;

  // The read-ahead buffer is either the last CPU-written byte (buf_reg) or
  // the last prefetched array word (pf_data). Keeping the array output
  // register free of reset lets it map onto the BRAM output latch.
  logic [7:0]            buf_reg;
  logic                  buf_from_mem;
  logic [7:0]            pf_data;
  logic [7:0]            read_buf;

  logic [7:0]            vid_q;
  logic                  vid_vld;

  logic [7:0]            mem [DEPTH];

  logic                  wr_go;
  logic                  rd_go;
  logic                  ctrl_wr;
  logic                  ctrl_rd;
  logic                  data_wr;
  logic                  data_rd;
  logic [13:0]           setup_addr;

  // Strobe decode: write wins over read, and nothing is accepted while a
  // prefetch is still outstanding.
  assign wr_go   = wr_tick & ~pf_vld_p1;
  assign rd_go   = rd_tick & ~wr_tick & ~pf_vld_p1;
  assign ctrl_wr = wr_go & mode;
  assign data_wr = wr_go & ~mode;
  assign ctrl_rd = rd_go & mode;
  assign data_rd = rd_go & ~mode;

  // Second control byte supplies the high address bits; bits above the
  // array size are dropped.
  assign setup_addr = {din[5:0], latch};

  assign read_buf = buf_from_mem ? pf_data : buf_reg;
  assign vid_data = vid_vld ? vid_q : 8'h00;

  // CPU side of the array: byte write and prefetch read share one port.
  always_ff @(posedge clk) begin
    if (data_wr) begin
      mem[addr] <= din;
    end
    if (pf_vld_p1) begin
      pf_data <= mem[addr];
    end
  end

  // Video side of the array: read-only, old data on a same-address write.
  always_ff @(posedge clk) begin
    if (vid_rd) begin
      vid_q <= mem[vid_addr];
    end
  end

  // Marks the video output register as loaded since the last reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_vld <= 1'b0;
    end else if (vid_rd) begin
      vid_vld <= 1'b1;
    end
  end

  // CPU port control: byte-pair FSM, address counter, read buffer, outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= FIRST;
      latch          <= 8'h00;
      addr           <= '0;
      pf_vld_p1      <= 1'b0;
      buf_reg        <= 8'h00;
      buf_from_mem   <= 1'b0;
      dout           <= 8'h00;
      status_rd_tick <= 1'b0;
      reg_wr_tick    <= 1'b0;
      reg_num        <= '0;
      reg_data       <= 8'h00;
    end else begin
      status_rd_tick <= 1'b0;
      reg_wr_tick    <= 1'b0;
      pf_vld_p1      <= 1'b0;

      // Prefetch completes: buffer now tracks the array word, advance.
      if (pf_vld_p1) begin
        buf_from_mem <= 1'b1;
        addr         <= addr + ADDR_ONE;
      end

      if (ctrl_wr) begin
        if (state == FIRST) begin
          latch <= din;
          state <= SECOND;
        end else begin
          state <= FIRST;
          case (din[7:6])
            2'b00: begin
              addr      <= setup_addr[ADDR_WIDTH-1:0];
              pf_vld_p1 <= 1'b1;
            end
            2'b01: begin
              addr <= setup_addr[ADDR_WIDTH-1:0];
            end
            2'b10: begin
              reg_num     <= din[REG_BITS-1:0];
              reg_data    <= latch;
              reg_wr_tick <= 1'b1;
            end
            default: begin
            end
          endcase
        end
      end else if (ctrl_rd) begin
        dout           <= status_in;
        status_rd_tick <= 1'b1;
        state          <= FIRST;
      end else if (data_wr) begin
        buf_reg      <= din;
        buf_from_mem <= 1'b0;
        addr         <= addr + ADDR_ONE;
        state        <= FIRST;
      end else if (data_rd) begin
        dout      <= read_buf;
        pf_vld_p1 <= 1'b1;
        state     <= FIRST;
      end
    end
  end

endmodule

// File: tb/tb_vram_cpu_vid.sv
// Testbench for vram_cpu_vid: fill/readback, table of CPU port vectors,
// and hand sequences for register writes, status pulse, video collision,
// strobe precedence and reset in the middle of an address setup.
module tb_vram_cpu_vid;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mode = 1'b0;
  logic        rd_tick = 1'b0;
  logic        wr_tick = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic [7:0]  status_in = 8'h00;
  logic        status_rd_tick;
  logic        reg_wr_tick;
  logic [2:0]  reg_num;
  logic [7:0]  reg_data;
  logic [13:0] vid_addr = 14'h0;
  logic        vid_rd = 1'b0;
  logic [7:0]  vid_data;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0] d;
    logic       st;
  } exp_t;
  exp_t sbq[$];

  localparam logic [1:0] OP_CW = 2'd0;
  localparam logic [1:0] OP_CR = 2'd1;
  localparam logic [1:0] OP_DW = 2'd2;
  localparam logic [1:0] OP_DR = 2'd3;

  typedef struct {
    logic [1:0] op;
    logic [7:0] d;
    logic [7:0] st;
    logic [7:0] expd;
  } vec_t;
  vec_t vt[$];

  vram_cpu_vid #(.ADDR_WIDTH(14), .REG_BITS(3)) dut (
    .clk(clk),
    .reset(reset),
    .mode(mode),
    .rd_tick(rd_tick),
    .wr_tick(wr_tick),
    .din(din),
    .dout(dout),
    .status_in(status_in),
    .status_rd_tick(status_rd_tick),
    .reg_wr_tick(reg_wr_tick),
    .reg_num(reg_num),
    .reg_data(reg_data),
    .vid_addr(vid_addr),
    .vid_rd(vid_rd),
    .vid_data(vid_data)
  );

  always #5 clk = ~clk;

  task automatic check8(input string nm, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // One-cycle strobe; read results are popped from the scoreboard when
  // the registered output appears.
  task automatic strobe(input logic m, input logic w, input logic r, input logic [7:0] d);
    exp_t e;
    @(posedge clk);
    #1;
    mode = m; wr_tick = w; rd_tick = r; din = d;
    @(posedge clk);
    #1;
    wr_tick = 1'b0; rd_tick = 1'b0;
    @(negedge clk);
    if (r && !w) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected got dout=%h want no read", dout);
      end else begin
        e = sbq.pop_front();
        if (dout !== e.d || status_rd_tick !== e.st) begin
          bad++;
          $display("FAIL rd_result got dout=%h st=%b want dout=%h st=%b",
                   dout, status_rd_tick, e.d, e.st);
        end
      end
    end
  endtask

  task automatic cw(input logic [7:0] d);
    strobe(1'b1, 1'b1, 1'b0, d);
  endtask

  task automatic dw(input logic [7:0] d);
    strobe(1'b0, 1'b1, 1'b0, d);
  endtask

  task automatic dr(input logic [7:0] expd);
    sbq.push_back('{d: expd, st: 1'b0});
    strobe(1'b0, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic cr(input logic [7:0] st, input logic [7:0] expd);
    status_in = st;
    sbq.push_back('{d: expd, st: 1'b1});
    strobe(1'b1, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic add(input logic [1:0] op, input logic [7:0] d, input logic [7:0] st,
                     input logic [7:0] expd);
    vt.push_back('{op: op, d: d, st: st, expd: expd});
  endtask

  task automatic check_all_zero(input string tag);
    check8({tag, "_dout"}, dout, 8'h00);
    check8({tag, "_vid_data"}, vid_data, 8'h00);
    check8({tag, "_reg_num"}, {5'b0, reg_num}, 8'h00);
    check8({tag, "_reg_data"}, reg_data, 8'h00);
    check8({tag, "_status_rd_tick"}, {7'b0, status_rd_tick}, 8'h00);
    check8({tag, "_reg_wr_tick"}, {7'b0, reg_wr_tick}, 8'h00);
  endtask

  initial begin
    // Out-of-phase read with wrap at the top of memory
    add(OP_CW, 8'hFE, 8'h00, 8'h00);
    add(OP_CW, 8'h3F, 8'h00, 8'h00);
    add(OP_DR, 8'h00, 8'h00, 8'hFE);
    add(OP_DR, 8'h00, 8'h00, 8'hFF);
    add(OP_DR, 8'h00, 8'h00, 8'h00);
    add(OP_DR, 8'h00, 8'h00, 8'h01);
    // Status read aborts a half-written address
    add(OP_CW, 8'h99, 8'h00, 8'h00);
    add(OP_CR, 8'h00, 8'hA5, 8'hA5);
    add(OP_CW, 8'h11, 8'h00, 8'h00);
    add(OP_CW, 8'h33, 8'h00, 8'h00);
    add(OP_DR, 8'h00, 8'h00, 8'h11);
    add(OP_DR, 8'h00, 8'h00, 8'h12);
    // Data write feeds the read buffer
    add(OP_CW, 8'h00, 8'h00, 8'h00);
    add(OP_CW, 8'h41, 8'h00, 8'h00);
    add(OP_DW, 8'h77, 8'h00, 8'h00);
    add(OP_DR, 8'h00, 8'h00, 8'h77);
    add(OP_DR, 8'h00, 8'h00, 8'h01);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Fill every location with its low address byte, then read it all back
    cw(8'h00);
    cw(8'h40);
    for (int i = 0; i < 16384; i++) begin
      dw(i[7:0]);
    end
    cw(8'h00);
    cw(8'h00);
    for (int i = 0; i < 16384; i++) begin
      dr(i[7:0]);
    end
    dr(8'h00);

    for (int k = 0; k < vt.size(); k++) begin
      case (vt[k].op)
        OP_CW: cw(vt[k].d);
        OP_CR: cr(vt[k].st, vt[k].expd);
        OP_DW: dw(vt[k].d);
        default: dr(vt[k].expd);
      endcase
    end

    // Register write: single pulse, values held, address untouched
    cw(8'h5A);
    cw(8'h87);
    check8("reg_wr_tick_hi", {7'b0, reg_wr_tick}, 8'h01);
    check8("reg_num", {5'b0, reg_num}, 8'h07);
    check8("reg_data", reg_data, 8'h5A);
    @(negedge clk);
    check8("reg_wr_tick_lo", {7'b0, reg_wr_tick}, 8'h00);
    check8("reg_num_held", {5'b0, reg_num}, 8'h07);
    dr(8'h02);
    dr(8'h03);

    // Status read pulse lasts one cycle
    cr(8'h3C, 8'h3C);
    @(negedge clk);
    check8("status_tick_lo", {7'b0, status_rd_tick}, 8'h00);
    check8("dout_hold", dout, 8'h3C);

    // Video port: plain read, then same-address collision with a CPU write
    @(posedge clk);
    #1;
    vid_rd = 1'b1; vid_addr = 14'h0201;
    @(posedge clk);
    #1;
    vid_rd = 1'b0;
    @(negedge clk);
    check8("vid_plain", vid_data, 8'h01);
    cw(8'h00);
    cw(8'h42);
    @(posedge clk);
    #1;
    mode = 1'b0; din = 8'h3C; wr_tick = 1'b1; vid_rd = 1'b1; vid_addr = 14'h0200;
    @(posedge clk);
    #1;
    wr_tick = 1'b0;
    @(negedge clk);
    check8("vid_collide_old", vid_data, 8'h00);
    @(posedge clk);
    #1;
    vid_rd = 1'b0; vid_addr = 14'h0201;
    @(negedge clk);
    check8("vid_after_write", vid_data, 8'h3C);
    @(posedge clk);
    @(negedge clk);
    check8("vid_hold", vid_data, 8'h3C);

    // Reset while the FSM waits for the second control byte
    cw(8'h55);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cw(8'h00);
    cw(8'h00);
    dr(8'h00);
    dr(8'h01);

    // Write and read strobes together: only the write happens
    cw(8'h00);
    cw(8'h43);
    strobe(1'b0, 1'b1, 1'b1, 8'hC3);
    check8("both_strobes_dout", dout, 8'h01);
    dr(8'hC3);
    dr(8'h01);

    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d want=0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
